// File: rtl/addsub_csel_pipe.sv
// Multi-cycle carry-select adder/subtractor with valid/ready handshake on both sides.
// Optional macro ADDSUB_CSEL_DUAL_BANK_EN: two adder banks compute both carry-in sums in one cycle.
module addsub_csel_pipe #(
  parameter int unsigned BLOCK = 128,
  parameter int unsigned NBLK  = 25
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK*NBLK-1:0]   a,
  input  logic [BLOCK*NBLK-1:0]   b,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK*NBLK-1:0]   c,
  output logic                    cout
);

  localparam int unsigned W  = BLOCK * NBLK;
  localparam int unsigned BW = BLOCK + 1;

  typedef enum logic [2:0] {IDLE, SUM0, SUM1, SEL, DONE} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    opa_q, opa_d;
  logic [W-1:0]    opb_q, opb_d;
  logic            subr_q, subr_d;
  logic [BW-1:0]   s0_q [NBLK];
  logic [BW-1:0]   s0_d [NBLK];
  logic [BW-1:0]   s1_q [NBLK];
  logic [BW-1:0]   s1_d [NBLK];
  logic [W-1:0]    c_q, c_d;
  logic            cout_q, cout_d;
  logic            out_valid_q, out_valid_d;

  logic            accept_c;
  logic [BW-1:0]   bank0_c [NBLK];
  logic [W-1:0]    c_sel_c;
  logic            carry_c;

  assign accept_c  = in_valid && in_ready;
  assign c         = c_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

`ifdef ADDSUB_CSEL_DUAL_BANK_EN
  logic [BW-1:0]   bank1_c [NBLK];

  // Both carry-in variants in parallel.
  always_comb begin
    for (int k = 0; k < int'(NBLK); k++) begin
      bank0_c[k] = BW'(opa_q[k*BLOCK +: BLOCK]) + BW'(opb_q[k*BLOCK +: BLOCK]);
      bank1_c[k] = BW'(opa_q[k*BLOCK +: BLOCK]) + BW'(opb_q[k*BLOCK +: BLOCK]) + BW'(1);
    end
  end
`else
  logic            bank_cin_c;

  // Single bank reused: cin=0 in SUM0, cin=1 in SUM1.
  always_comb begin
    bank_cin_c = (state_q == SUM1);
    for (int k = 0; k < int'(NBLK); k++) begin
      bank0_c[k] = BW'(opa_q[k*BLOCK +: BLOCK]) + BW'(opb_q[k*BLOCK +: BLOCK])
                 + BW'(bank_cin_c);
    end
  end
`endif

  // Ripple carry through the per-block selects; chain seeded with subr for two's complement.
  always_comb begin
    logic [BW-1:0] sel;
    c_sel_c = '0;
    carry_c = subr_q;
    sel     = '0;
    for (int k = 0; k < int'(NBLK); k++) begin
      sel = carry_c ? s1_q[k] : s0_q[k];
      c_sel_c[k*BLOCK +: BLOCK] = sel[BLOCK-1:0];
      carry_c = sel[BLOCK];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_c) state_d = SUM0;
`ifdef ADDSUB_CSEL_DUAL_BANK_EN
      SUM0: state_d = SEL;
`else
      SUM0: state_d = SUM1;
      SUM1: state_d = SEL;
`endif
      SEL:  state_d = DONE;
      DONE: if (out_ready) state_d = accept_c ? SUM0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is combinational so a DONE handshake and a new accept can share one edge.
  always_comb begin
    in_ready = 1'b0;
    if (!rst && ((state_q == IDLE) || (state_q == DONE && out_ready))) in_ready = 1'b1;
  end

  always_comb begin
    opa_d       = opa_q;
    opb_d       = opb_q;
    subr_d      = subr_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    c_d         = c_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    if (accept_c) begin
      opa_d  = a;
      opb_d  = sub ? ~b : b;
      subr_d = sub;
    end
    case (state_q)
`ifdef ADDSUB_CSEL_DUAL_BANK_EN
      SUM0: begin
        s0_d = bank0_c;
        s1_d = bank1_c;
      end
`else
      SUM0: s0_d = bank0_c;
      SUM1: s1_d = bank0_c;
`endif
      SEL: begin
        c_d         = c_sel_c;
        cout_d      = carry_c ^ subr_q;
        out_valid_d = 1'b1;
      end
      DONE: if (out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q       <= '0;
      opb_q       <= '0;
      subr_q      <= 1'b0;
      for (int k = 0; k < int'(NBLK); k++) begin
        s0_q[k] <= '0;
        s1_q[k] <= '0;
      end
      c_q         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      subr_q      <= subr_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      c_q         <= c_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_addsub_csel_pipe.sv
// Directed bench for addsub_csel_pipe: small 4x8-bit instance plus a default-size instance.
module tb_addsub_csel_pipe;

`ifdef ADDSUB_CSEL_DUAL_BANK_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif
  localparam int NV = 8;
  localparam int BW = 3200;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sub, out_valid, out_ready, cout;
  logic [31:0] a, b, c;

  logic          big_in_valid, big_in_ready, big_sub, big_out_valid, big_out_ready, big_cout;
  logic [BW-1:0] big_a, big_b, big_c, big_exp;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] c;
    logic        cout;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  addsub_csel_pipe #(.BLOCK(8), .NBLK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .cout(cout)
  );

  addsub_csel_pipe dut_big (
    .clk(clk), .rst(rst), .in_valid(big_in_valid), .in_ready(big_in_ready),
    .a(big_a), .b(big_b), .sub(big_sub), .out_valid(big_out_valid),
    .out_ready(big_out_ready), .c(big_c), .cout(big_cout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_big_valid(output int n);
    n = 0;
    while (big_out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[1] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b0};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b1};
    vecs[3] = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 32'h2143_6587, 1'b0};
    vecs[4] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
    big_in_valid = 1'b0; big_out_ready = 1'b0; big_sub = 1'b0; big_a = '0; big_b = '0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_c", 64'(c), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < NV; i++) begin
      a = vecs[i].a; b = vecs[i].b; sub = vecs[i].sub; in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_busy", i), 64'(out_valid), 64'd0);
      wait_valid(n);
      chk($sformatf("v%0d_lat", i), 64'(n), 64'(LAT));
      chk($sformatf("v%0d_c", i), 64'(c), 64'(vecs[i].c));
      chk($sformatf("v%0d_cout", i), 64'(cout), 64'(vecs[i].cout));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("v%0d_drop", i), 64'(out_valid), 64'd0);
      chk($sformatf("v%0d_hold", i), 64'(c), 64'(vecs[i].c));
    end

    // Backpressure: result held, ignored in_valid, then same-edge handshake + accept.
    a = 32'h0000_00F0; b = 32'h0000_0010; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    chk("bp_lat", 64'(n), 64'(LAT));
    for (int j = 0; j < 5; j++) begin
      if (j == 2) begin
        in_valid = 1'b1; a = 32'h1111_1111; b = 32'h2222_2222;
      end
      #1;
      chk($sformatf("bp%0d_in_ready", j), 64'(in_ready), 64'd0);
      tick();
      in_valid = 1'b0;
      chk($sformatf("bp%0d_valid", j), 64'(out_valid), 64'd1);
      chk($sformatf("bp%0d_c", j), 64'(c), 64'h100);
      chk($sformatf("bp%0d_cout", j), 64'(cout), 64'd0);
    end
    a = 32'd3; b = 32'd4; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("bp_same_edge_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_handshake_drop", 64'(out_valid), 64'd0);
    wait_valid(n);
    chk("bp_next_lat", 64'(n), 64'(LAT));
    chk("bp_next_c", 64'(c), 64'd7);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during the second computation cycle.
    a = 32'd9; b = 32'd1; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_c", 64'(c), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("post_rst%0d_valid", j), 64'(out_valid), 64'd0);
    end
    a = 32'd3; b = 32'd4; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    chk("post_rst_lat", 64'(n), 64'(LAT));
    chk("post_rst_c", 64'(c), 64'd7);
    chk("post_rst_cout", 64'(cout), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Default-size instance: carry crosses block 0 into block 1.
    big_a = '0; big_a[BW-1] = 1'b1; big_a[127:0] = '1;
    big_b = '0; big_b[0] = 1'b1;
    big_exp = '0; big_exp[BW-1] = 1'b1; big_exp[128] = 1'b1;
    big_sub = 1'b0; big_in_valid = 1'b1;
    #1;
    chk("big_ready", 64'(big_in_ready), 64'd1);
    tick();
    big_in_valid = 1'b0;
    wait_big_valid(n);
    chk("big_lat", 64'(n), 64'(LAT));
    chk("big_c_top", big_c[BW-1 -: 64], big_exp[BW-1 -: 64]);
    chk("big_c_blk1", big_c[191:128], big_exp[191:128]);
    chk("big_c_blk0", big_c[63:0], big_exp[63:0]);
    chk("big_c_full_ne", 64'(big_c !== big_exp), 64'd0);
    chk("big_cout", 64'(big_cout), 64'd0);
    big_out_ready = 1'b1;
    tick();
    big_out_ready = 1'b0;
    chk("big_drop", 64'(big_out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
